// File: rtl/riscv_core_pkg.sv
// rtl/riscv_core_pkg.sv - shared constants for the five-stage core hazard logic
// Contents: EX operand forwarding select encodings, register-index width, x0 index.
package riscv_core_pkg;

    localparam int REG_AW = 5;

    localparam logic [4:0] X0 = 5'd0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/riscv_core_fwd_sel.sv
// rtl/riscv_core_fwd_sel.sv - EX operand forwarding select for one source operand
// Ports:
//   rs           - source register of the EX instruction
//   rd_mem/rd_wb - destination registers in MEM / WB
//   regwrite_mem/regwrite_wb - MEM / WB instruction writes its rd
//   fwd          - select: FWD_RF, FWD_WB or FWD_MEM
module riscv_core_fwd_sel
    import riscv_core_pkg::*;
#(
    parameter int REG_AW = riscv_core_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              regwrite_mem,
    input  logic              regwrite_wb,
    output logic [1:0]        fwd
);

    logic rs_nonzero;

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    assign rs_nonzero = (rs != REG_AW'(X0));

    // MEM is checked first: it holds the younger, more recent value.
    always_comb begin
        fwd = FWD_RF;
        if (regwrite_mem && rs_nonzero && (rs == rd_mem)) begin
            fwd = FWD_MEM;
        end else if (regwrite_wb && rs_nonzero && (rs == rd_wb)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/riscv_core_hazard_unit.sv
// rtl/riscv_core_hazard_unit.sv - forwarding, load-use stall and branch flush control
// Ports:
//   clk, rst                     - core clock, synchronous active-high reset
//   i_hazard_unit_rs1/rs2_id     - ID source registers
//   i_hazard_unit_rs1/rs2_ex     - EX source registers
//   i_hazard_unit_rd_ex/mem/wb   - destination register per stage
//   i_hazard_unit_regwrite_mem/wb - MEM / WB write rd
//   i_hazard_unit_resultsrc0_ex  - EX instruction is a load
//   i_hazard_unit_pcsrc_ex       - taken branch / jump resolved in EX
//   o_hazard_unit_forwarda/b_ex  - EX operand selects
//   o_hazard_unit_stall_if/id    - hold PC / hold IF/ID
//   o_hazard_unit_flush_id/ex    - clear IF/ID / clear ID/EX
module riscv_core_hazard_unit
    import riscv_core_pkg::*;
#(
    parameter int REG_AW = riscv_core_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_hazard_unit_rs1_id,
    input  logic [REG_AW-1:0] i_hazard_unit_rs2_id,
    input  logic [REG_AW-1:0] i_hazard_unit_rs1_ex,
    input  logic [REG_AW-1:0] i_hazard_unit_rs2_ex,
    input  logic [REG_AW-1:0] i_hazard_unit_rd_ex,
    input  logic [REG_AW-1:0] i_hazard_unit_rd_mem,
    input  logic [REG_AW-1:0] i_hazard_unit_rd_wb,
    input  logic              i_hazard_unit_regwrite_mem,
    input  logic              i_hazard_unit_regwrite_wb,
    input  logic              i_hazard_unit_resultsrc0_ex,
    input  logic              i_hazard_unit_pcsrc_ex,
    output logic [1:0]        o_hazard_unit_forwarda_ex,
    output logic [1:0]        o_hazard_unit_forwardb_ex,
    output logic              o_hazard_unit_stall_if,
    output logic              o_hazard_unit_stall_id,
    output logic              o_hazard_unit_flush_id,
    output logic              o_hazard_unit_flush_ex
);

    logic       rst_q;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       lw_stall;

    // Reset takes effect one edge late so the decision in the cycle where
    // rst rises is still driven from the live inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
        end
    end

    riscv_core_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs           (i_hazard_unit_rs1_ex),
        .rd_mem       (i_hazard_unit_rd_mem),
        .rd_wb        (i_hazard_unit_rd_wb),
        .regwrite_mem (i_hazard_unit_regwrite_mem),
        .regwrite_wb  (i_hazard_unit_regwrite_wb),
        .fwd          (fwd_a)
    );

    riscv_core_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs           (i_hazard_unit_rs2_ex),
        .rd_mem       (i_hazard_unit_rd_mem),
        .rd_wb        (i_hazard_unit_rd_wb),
        .regwrite_mem (i_hazard_unit_regwrite_mem),
        .regwrite_wb  (i_hazard_unit_regwrite_wb),
        .fwd          (fwd_b)
    );

    // No x0 exclusion here: a load to x0 stalls for a cycle, which is harmless.
    assign lw_stall = i_hazard_unit_resultsrc0_ex &
                      ((i_hazard_unit_rs1_id == i_hazard_unit_rd_ex) |
                       (i_hazard_unit_rs2_id == i_hazard_unit_rd_ex));

    // Flushing ID/EX during a stall turns the load-use pair into one bubble,
    // and it also clears resultsrc0_ex so the stall releases on its own.
    always_comb begin
        o_hazard_unit_forwarda_ex = FWD_RF;
        o_hazard_unit_forwardb_ex = FWD_RF;
        o_hazard_unit_stall_if    = 1'b0;
        o_hazard_unit_stall_id    = 1'b0;
        o_hazard_unit_flush_id    = 1'b1;
        o_hazard_unit_flush_ex    = 1'b1;
        if (!rst_q) begin
            o_hazard_unit_forwarda_ex = fwd_a;
            o_hazard_unit_forwardb_ex = fwd_b;
            o_hazard_unit_stall_if    = lw_stall;
            o_hazard_unit_stall_id    = lw_stall;
            o_hazard_unit_flush_id    = i_hazard_unit_pcsrc_ex;
            o_hazard_unit_flush_ex    = lw_stall | i_hazard_unit_pcsrc_ex;
        end
    end

endmodule

// File: tb/tb_riscv_core_hazard_unit.sv
// tb/tb_riscv_core_hazard_unit.sv - self-checking bench for riscv_core_hazard_unit
module tb_riscv_core_hazard_unit;

    typedef struct {
        logic [4:0] rs1_id;
        logic [4:0] rs2_id;
        logic [4:0] rs1_ex;
        logic [4:0] rs2_ex;
        logic [4:0] rd_ex;
        logic [4:0] rd_mem;
        logic [4:0] rd_wb;
        logic       rw_mem;
        logic       rw_wb;
        logic       ld;
        logic       pc;
        logic [7:0] exp;   // {fwd_a, fwd_b, stall_if, stall_id, flush_id, flush_ex}
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic       rw_mem, rw_wb, ld, pc;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_if, stall_id, flush_id, flush_ex;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];
    vec_t       table_v[$];

    localparam logic [7:0] RST_OUT = 8'b0000_0011;

    always #5 clk = ~clk;

    riscv_core_hazard_unit #(.REG_AW(5)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .i_hazard_unit_rs1_id        (rs1_id),
        .i_hazard_unit_rs2_id        (rs2_id),
        .i_hazard_unit_rs1_ex        (rs1_ex),
        .i_hazard_unit_rs2_ex        (rs2_ex),
        .i_hazard_unit_rd_ex         (rd_ex),
        .i_hazard_unit_rd_mem        (rd_mem),
        .i_hazard_unit_rd_wb         (rd_wb),
        .i_hazard_unit_regwrite_mem  (rw_mem),
        .i_hazard_unit_regwrite_wb   (rw_wb),
        .i_hazard_unit_resultsrc0_ex (ld),
        .i_hazard_unit_pcsrc_ex      (pc),
        .o_hazard_unit_forwarda_ex   (fwd_a),
        .o_hazard_unit_forwardb_ex   (fwd_b),
        .o_hazard_unit_stall_if      (stall_if),
        .o_hazard_unit_stall_id      (stall_id),
        .o_hazard_unit_flush_id      (flush_id),
        .o_hazard_unit_flush_ex      (flush_ex)
    );

    function automatic vec_t mk(input logic [4:0] a_rs1_id, input logic [4:0] a_rs2_id,
                                input logic [4:0] a_rs1_ex, input logic [4:0] a_rs2_ex,
                                input logic [4:0] a_rd_ex, input logic [4:0] a_rd_mem,
                                input logic [4:0] a_rd_wb, input logic a_rw_mem,
                                input logic a_rw_wb, input logic a_ld, input logic a_pc,
                                input logic [7:0] a_exp, input string a_name);
        vec_t v;
        v.rs1_id = a_rs1_id; v.rs2_id = a_rs2_id;
        v.rs1_ex = a_rs1_ex; v.rs2_ex = a_rs2_ex;
        v.rd_ex = a_rd_ex; v.rd_mem = a_rd_mem; v.rd_wb = a_rd_wb;
        v.rw_mem = a_rw_mem; v.rw_wb = a_rw_wb; v.ld = a_ld; v.pc = a_pc;
        v.exp = a_exp; v.name = a_name;
        return v;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input vec_t v);
        if (v.rw_mem && rs == v.rd_mem && rs != 5'd0) return 2'b10;
        if (v.rw_wb && rs == v.rd_wb && rs != 5'd0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [7:0] ref_model(input vec_t v);
        logic lw;
        lw = v.ld & ((v.rs1_id == v.rd_ex) | (v.rs2_id == v.rd_ex));
        return {ref_fwd(v.rs1_ex, v), ref_fwd(v.rs2_ex, v), lw, lw, v.pc, lw | v.pc};
    endfunction

    task automatic check_out();
        logic [7:0] act;
        logic [7:0] exp;
        string      nm;
        act = {fwd_a, fwd_b, stall_if, stall_id, flush_id, flush_ex};
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b (fa fb sif sid fid fex)", nm, act, exp);
        end
    endtask

    // Drive just after a posedge, sample at the following negedge.
    task automatic drive(input vec_t v, input logic r);
        @(posedge clk);
        #1;
        rst = r;
        rs1_id = v.rs1_id; rs2_id = v.rs2_id; rs1_ex = v.rs1_ex; rs2_ex = v.rs2_ex;
        rd_ex = v.rd_ex; rd_mem = v.rd_mem; rd_wb = v.rd_wb;
        rw_mem = v.rw_mem; rw_wb = v.rw_wb; ld = v.ld; pc = v.pc;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t s;
        vec_t v;
        rst = 1'b1;
        rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0;
        rd_ex = '0; rd_mem = '0; rd_wb = '0;
        rw_mem = 0; rw_wb = 0; ld = 0; pc = 0;

        // Forward A from MEM plus a load-use match: normal response is 10/00/1/1/0/1.
        s = mk(5'd10, 5'd1, 5'd5, 5'd2, 5'd10, 5'd5, 5'd6, 1, 1, 1, 0, 8'b1000_1101, "");

        s.exp = RST_OUT; s.name = "reset_state";     drive(s, 1'b1);
        s.name = "reset_release_edge";                drive(s, 1'b0);
        s.exp = 8'b1000_1101; s.name = "after_reset"; drive(s, 1'b0);

        table_v.push_back(mk(5'd0, 5'd0, 5'd3, 5'd27, 5'd1, 5'd27, 5'd5, 1, 1, 0, 0, 8'b0010_0000, "mem_fwd_b"));
        table_v.push_back(mk(5'd19, 5'd1, 5'd0, 5'd0, 5'd19, 5'd0, 5'd0, 0, 0, 1, 0, 8'b0000_1101, "lu_stall_rs1"));
        table_v.push_back(mk(5'd2, 5'd19, 5'd0, 5'd0, 5'd19, 5'd0, 5'd0, 0, 0, 1, 0, 8'b0000_1101, "lu_stall_rs2"));
        table_v.push_back(mk(5'd2, 5'd19, 5'd0, 5'd0, 5'd19, 5'd0, 5'd0, 0, 0, 0, 0, 8'b0000_0000, "stall_release"));
        table_v.push_back(mk(5'd0, 5'd0, 5'd7, 5'd0, 5'd1, 5'd7, 5'd7, 1, 1, 0, 0, 8'b1000_0000, "mem_over_wb"));
        table_v.push_back(mk(5'd1, 5'd2, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1, 1, 0, 0, 8'b0000_0000, "x0_no_fwd"));
        table_v.push_back(mk(5'd1, 5'd2, 5'd9, 5'd0, 5'd3, 5'd4, 5'd9, 1, 1, 0, 0, 8'b0100_0000, "wb_fwd_a"));
        table_v.push_back(mk(5'd1, 5'd2, 5'd12, 5'd12, 5'd3, 5'd12, 5'd12, 0, 1, 0, 0, 8'b0101_0000, "mem_rw_off_wb"));
        table_v.push_back(mk(5'd19, 5'd1, 5'd0, 5'd0, 5'd19, 5'd0, 5'd0, 0, 0, 1, 1, 8'b0000_1111, "branch_in_stall"));
        table_v.push_back(mk(5'd1, 5'd2, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 0, 0, 0, 1, 8'b0000_0011, "branch_only"));
        table_v.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'b0000_1101, "load_x0_stall"));
        table_v.push_back(mk(5'd6, 5'd7, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 0, 0, 1, 0, 8'b0000_0000, "load_no_match"));
        table_v.push_back(mk(5'd1, 5'd2, 5'd3, 5'd8, 5'd4, 5'd3, 5'd8, 1, 1, 0, 0, 8'b1001_0000, "fwd_a_mem_b_wb"));
        table_v.push_back(mk(5'd1, 5'd2, 5'd14, 5'd14, 5'd4, 5'd3, 5'd14, 1, 0, 0, 0, 8'b0000_0000, "wb_rw_off"));

        foreach (table_v[i]) drive(table_v[i], 1'b0);

        // Mid-operation reset: the rising cycle is unaffected, then reset
        // outputs hold until one posedge after rst falls.
        s.exp = 8'b1000_1101; s.name = "mid_rst_rise";  drive(s, 1'b1);
        s.exp = RST_OUT;      s.name = "mid_rst_hold";  drive(s, 1'b1);
        s.name = "mid_rst_fall_edge";                   drive(s, 1'b0);
        s.exp = 8'b1000_1101; s.name = "mid_rst_track"; drive(s, 1'b0);

        // Back-to-back loads: stall, bubble (load flushed from EX), stall again.
        s = mk(5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 0, 0, 1, 0, 8'b0000_1101, "b2b_load1");
        drive(s, 1'b0);
        s.ld = 0; s.rd_ex = 5'd0; s.exp = 8'b0000_0000; s.name = "b2b_bubble";
        drive(s, 1'b0);
        s.ld = 1; s.rd_ex = 5'd4; s.exp = 8'b0000_1101; s.name = "b2b_load2";
        drive(s, 1'b0);

        for (int n = 0; n < 150; n++) begin
            v.rs1_id = 5'($urandom_range(0, 3)); v.rs2_id = 5'($urandom_range(0, 3));
            v.rs1_ex = 5'($urandom_range(0, 3)); v.rs2_ex = 5'($urandom_range(0, 3));
            v.rd_ex  = 5'($urandom_range(0, 3)); v.rd_mem = 5'($urandom_range(0, 3));
            v.rd_wb  = 5'($urandom_range(0, 3));
            v.rw_mem = 1'($urandom_range(0, 1)); v.rw_wb = 1'($urandom_range(0, 1));
            v.ld     = 1'($urandom_range(0, 1)); v.pc    = 1'($urandom_range(0, 1));
            v.exp    = ref_model(v);
            v.name   = "random";
            drive(v, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
